lsu_bus_initiator: RTL and testbench
====================================

Name: lsu_bus_initiator

Overview:
- Initiator side of the data-memory interface: takes one load/store from the MEM pipeline stage and issues it as a valid/ready request on a word-oriented data bus.
- Waits for the read response, then extracts and sign/zero-extends load data.
- Stalls the pipeline while a transaction is outstanding.
- Sits between the MEM pipeline register and a multi-cycle data memory responder.

Parameters:
- DATA_WIDTH, 32, data/address width; fixed at 32 (byte lanes assume 4 bytes).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  MEM stage holds a load or store
- mem_write  in  1  1 = store, 0 = load
- type_control  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- sign_ext_flag  in  1  1 = sign-extend load, 0 = zero-extend
- addr  in  DATA_WIDTH  byte address (ALU result)
- write_data  in  DATA_WIDTH  store data, value in low bits
- stall_o  out  1  hold pipeline; request inputs must stay stable while high
- done_o  out  1  one-cycle pulse when the transaction completes
- misaligned_o  out  1  access is misaligned; no bus transaction is issued
- read_data_o  out  DATA_WIDTH  formatted load result; valid while done_o is high
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  responder accepts the request
- bus_we  out  1  write request
- bus_addr  out  DATA_WIDTH  word-aligned address, {addr[31:2],2'b00}
- bus_wdata  out  DATA_WIDTH  lane-replicated store data
- bus_wstrb  out  4  byte write strobes
- bus_rsp_valid  in  1  read data valid
- bus_rdata  in  DATA_WIDTH  read data word

Behaviour:

Reset:
- Reset value of every output is 0: state IDLE, stall_o, done_o, misaligned_o, read_data_o, and all bus_* outputs.

Misalignment:
- Combinational: misaligned_o = req_valid & (half & addr[0] | word & addr[1:0]!=0), asserted in IDLE only.
- When misaligned: stall_o = 0 and no request is issued. The pipeline handles the trap.

State machine (IDLE, REQ, WAIT_RSP, DONE):
- IDLE:
  - stall_o = req_valid & ~misaligned_o, combinational, so the pipeline freezes in the same cycle.
  - If req_valid & aligned: latch mem_write, type, sign flag, addr[1:0], bus_addr, bus_wdata, bus_wstrb; go to REQ.
- REQ:
  - bus_req_valid = 1, with all bus fields held stable until bus_req_ready.
  - On ready: a store goes to DONE (writes complete on acceptance); a load goes to WAIT_RSP.
- WAIT_RSP:
  - On bus_rsp_valid: register the formatted load data into read_data_o; go to DONE.
- DONE:
  - done_o = 1, stall_o = 0 so the pipeline advances this cycle.
  - req_valid is ignored here (it is the old request); next state is IDLE.

Latency:
- Store: 2 cycles minimum (IDLE→REQ→DONE) when ready is immediate.
- Load: 3 cycles minimum (IDLE→REQ→WAIT_RSP→DONE), plus wait cycles.
- stall_o is high for every cycle from the first request cycle through the last REQ/WAIT_RSP cycle.

Write formatting (o = addr[1:0]):
- Byte: wstrb = 4'b0001<<o; wdata = {4{wd[7:0]}}.
- Half: wstrb = 4'b0011<<o; wdata = {2{wd[15:0]}}.
- Word: wstrb = 4'b1111; wdata = wd.
- Loads drive wstrb = 0, wdata = 0, bus_we = 0.

Load formatting:
- Byte: select rdata[8*o+:8].
- Half: select rdata[16*o[1]+:16].
- Extend to 32 bits using sign_ext_flag. Word: pass rdata unchanged.

Boundary conditions:
- bus_rsp_valid outside WAIT_RSP is ignored; the responder never returns data in the acceptance cycle.
- rst mid-transaction: next cycle is IDLE with bus_req_valid = 0 and stall_o = 0; a late response is discarded.
- read_data_o holds its last value outside DONE.
- Back-to-back requests: after DONE a new request is accepted in the following IDLE cycle, so there is one bubble cycle.

Test Plan:
- Word store, addr=0x100, wd=0xDEADBEEF, ready tied 1 -> cycle 1: bus_req_valid=1, addr 0x100, wstrb 1111, we=1; cycle 2: done_o=1, stall_o=0.
- Byte load, addr=0x203, sign_ext=1, rdata=0x80FF_0000 returned 3 cycles after accept -> read_data_o=0xFFFFFF80 with done_o; stall_o high for all wait cycles.
- Half store, addr=0x302, wd=0x0000ABCD, ready held low 4 cycles -> bus_addr=0x300, wstrb 1100, wdata 0xABCDABCD stable all 4 cycles; done_o one cycle after ready.
- Half load, addr=0x401 -> misaligned_o=1 the same cycle, stall_o=0, bus_req_valid never asserted; byte load, addr=0x402, zero-extend, rdata=0x00F00000 -> read_data_o=0x000000F0.
- rst asserted while in WAIT_RSP, then bus_rsp_valid pulses -> state IDLE, done_o stays 0, read_data_o=0, stall_o=0.

Source files
------------

// File: rtl/lsu_bus_initiator_if.sv
// Word-oriented data bus between the LSU initiator and a multi-cycle memory responder.
// Requests use a valid/ready handshake; read data returns later on rsp_valid.
interface lsu_bus_initiator_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  bus_req_valid;
  logic                  bus_req_ready;
  logic                  bus_we;
  logic [DATA_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [3:0]            bus_wstrb;
  logic                  bus_rsp_valid;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_initiator.sv
// Issues one MEM-stage load/store as a bus transaction, stalls the pipeline while it is
// outstanding, and returns sign/zero-extended load data with a one-cycle done pulse.
module lsu_bus_initiator #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  mem_write,
  input  logic [1:0]            type_control,
  input  logic                  sign_ext_flag,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  misaligned_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  lsu_bus_initiator_if.master   bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t                state_q, state_d;
  logic                  we_q;
  logic [1:0]            type_q;
  logic                  sext_q;
  logic [1:0]            off_q;
  logic [DATA_WIDTH-3:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  capture;
  logic                  load_rsp;
  logic                  misaligned;
  logic [3:0]            wstrb_fmt;
  logic [DATA_WIDTH-1:0] wdata_fmt;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_fmt;

  // Reserved type 11 behaves as a word access.
  assign misaligned = (state_q == IDLE) & req_valid &
                      (((type_control == 2'b01) & addr[0]) |
                       (type_control[1] & (addr[1:0] != 2'b00)));

  always_comb begin
    wstrb_fmt = 4'b0000;
    wdata_fmt = '0;
    if (mem_write) begin
      unique case (type_control)
        2'b00: begin
          wstrb_fmt = 4'b0001 << addr[1:0];
          wdata_fmt = {4{write_data[7:0]}};
        end
        2'b01: begin
          wstrb_fmt = 4'b0011 << addr[1:0];
          wdata_fmt = {2{write_data[15:0]}};
        end
        default: begin
          wstrb_fmt = 4'b1111;
          wdata_fmt = write_data;
        end
      endcase
    end
  end

  assign byte_sel = bus.bus_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = bus.bus_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    unique case (type_q)
      2'b00:   load_fmt = {{(DATA_WIDTH-8){sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = {{(DATA_WIDTH-16){sext_q & half_sel[15]}}, half_sel};
      default: load_fmt = bus.bus_rdata;
    endcase
  end

  // Stall is combinational in IDLE so the pipeline freezes in the request cycle itself.
  always_comb begin
    state_d  = state_q;
    stall_o  = 1'b0;
    done_o   = 1'b0;
    capture  = 1'b0;
    load_rsp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !misaligned) begin
          stall_o = 1'b1;
          capture = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (bus.bus_req_ready) state_d = we_q ? DONE : WAIT_RSP;
      end
      WAIT_RSP: begin
        stall_o = 1'b1;
        if (bus.bus_rsp_valid) begin
          load_rsp = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      type_q  <= 2'b00;
      sext_q  <= 1'b0;
      off_q   <= 2'b00;
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'b0000;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        we_q    <= mem_write;
        type_q  <= type_control;
        sext_q  <= sign_ext_flag;
        off_q   <= addr[1:0];
        waddr_q <= addr[DATA_WIDTH-1:2];
        wdata_q <= wdata_fmt;
        wstrb_q <= wstrb_fmt;
      end
      if (load_rsp) rdata_q <= load_fmt;
    end
  end

  assign misaligned_o      = misaligned;
  assign read_data_o       = rdata_q;
  assign bus.bus_req_valid = (state_q == REQ);
  assign bus.bus_we        = we_q;
  assign bus.bus_addr      = {waddr_q, 2'b00};
  assign bus.bus_wdata     = wdata_q;
  assign bus.bus_wstrb     = wstrb_q;

endmodule

// File: tb/tb_lsu_bus_initiator.sv
// Randomized scoreboard bench for lsu_bus_initiator with a behavioural responder and
// an access-size/offset reference model.
module tb_lsu_bus_initiator;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        mem_write;
  logic [1:0]  type_control;
  logic        sign_ext_flag;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        stall_o;
  logic        done_o;
  logic        misaligned_o;
  logic [31:0] read_data_o;

  lsu_bus_initiator_if #(.DATA_WIDTH(32)) bus_if ();

  lsu_bus_initiator #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .mem_write    (mem_write),
    .type_control (type_control),
    .sign_ext_flag(sign_ext_flag),
    .addr         (addr),
    .write_data   (write_data),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .misaligned_o (misaligned_o),
    .read_data_o  (read_data_o),
    .bus          (bus_if.master)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  req_t        exp_req[$];
  logic [31:0] exp_done[$];
  logic [31:0] last_rd = 32'h0;
  bit          auto_en = 1'b0;
  bit          ovr_en  = 1'b0;
  logic [31:0] ovr_val = 32'h0;
  int          force_wait = -1;
  int          force_lat  = -1;
  bit          abort = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A1234;
  endfunction

  function automatic int acc_size(input logic [1:0] typ);
    return (typ == 2'd0) ? 1 : (typ == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input int size,
                                           input int o, input logic sx);
    logic [31:0] v;
    logic [31:0] mask;
    if (size == 4) return w;
    mask = (32'h1 << (8 * size)) - 32'h1;
    v = (w >> (8 * o)) & mask;
    if (sx && v[8 * size - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Responder: random ready delay, then for loads a response 1..4 cycles after acceptance.
  initial begin
    bit          we_cap;
    logic [31:0] a_cap;
    int          w;
    int          lat;
    bus_if.bus_req_ready = 1'b0;
    bus_if.bus_rsp_valid = 1'b0;
    bus_if.bus_rdata     = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!auto_en) continue;
      if (!bus_if.bus_req_valid) begin
        bus_if.bus_rsp_valid = ($urandom_range(0, 3) == 0);
        bus_if.bus_rdata     = $urandom;
        continue;
      end
      bus_if.bus_rsp_valid = 1'b0;
      w = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
      repeat (w) begin @(posedge clk); #1; end
      we_cap = bus_if.bus_we;
      a_cap  = bus_if.bus_addr;
      bus_if.bus_req_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.bus_req_ready = 1'b0;
      if (!we_cap) begin
        lat = (force_lat > 0) ? force_lat : $urandom_range(1, 4);
        repeat (lat - 1) begin @(posedge clk); #1; end
        bus_if.bus_rsp_valid = 1'b1;
        bus_if.bus_rdata     = ovr_en ? ovr_val : mem_word(a_cap);
        @(posedge clk); #1;
        bus_if.bus_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: compares every presented request and every done pulse against the queues.
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (bus_if.bus_req_valid) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual=valid addr=%h required=no request", bus_if.bus_addr);
        end else begin
          e = exp_req[0];
          check("bus_we", 32'(bus_if.bus_we), 32'(e.we));
          check("bus_addr", bus_if.bus_addr, e.addr);
          check("bus_wdata", bus_if.bus_wdata, e.wdata);
          check("bus_wstrb", 32'(bus_if.bus_wstrb), 32'(e.wstrb));
          if (bus_if.bus_req_ready) void'(exp_req.pop_front());
        end
      end
      if (done_o) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          check("read_data", read_data_o, exp_done.pop_front());
          check("stall_in_done", 32'(stall_o), 32'h0);
        end
      end
    end
  end

  task automatic do_txn(input logic we, input logic [1:0] typ, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
    int          size;
    int          o;
    bit          mis;
    int          n;
    req_t        r;
    logic [31:0] word;
    logic [31:0] exp_rd;
    size = acc_size(typ);
    o    = int'(a[1:0]);
    mis  = (o % size) != 0;
    @(posedge clk); #1;
    req_valid = 1'b1; mem_write = we; type_control = typ;
    sign_ext_flag = sx; addr = a; write_data = wd;
    #1;
    check("misaligned", 32'(misaligned_o), 32'(mis));
    check("stall_first", 32'(stall_o), 32'(!mis));
    if (mis) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      return;
    end
    r.addr = a & 32'hFFFF_FFFC;
    r.we   = we;
    if (we) begin
      r.wstrb = 4'(((1 << size) - 1) << o);
      r.wdata = (size == 1) ? wd[7:0] * 32'h0101_0101 :
                (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
      exp_rd  = last_rd;
    end else begin
      r.wstrb = 4'h0;
      r.wdata = 32'h0;
      word    = ovr_en ? ovr_val : mem_word(r.addr);
      exp_rd  = fmt_load(word, size, o, sx);
      last_rd = exp_rd;
    end
    exp_req.push_back(r);
    exp_done.push_back(exp_rd);
    n = 0;
    while (n < 60) begin
      @(posedge clk); #2;
      if (done_o) break;
      check("stall_busy", 32'(stall_o), 32'h1);
      n++;
    end
    if (n >= 60) begin
      checks++; errors++; abort = 1'b1;
      $display("FAIL timeout_done actual=no done after %0d cycles required=done", n);
      return;
    end
    if (force_wait == 0 && force_lat > 0)
      check("latency", 32'(n), we ? 32'd1 : 32'(1 + force_lat));
  endtask

  task automatic idle_cycles(input int k);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (k) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_write = 1'b0; type_control = 2'b00;
    sign_ext_flag = 1'b0; addr = 32'h0; write_data = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_misaligned", 32'(misaligned_o), 32'h0);
    check("rst_read_data", read_data_o, 32'h0);
    check("rst_req_valid", 32'(bus_if.bus_req_valid), 32'h0);
    check("rst_we", 32'(bus_if.bus_we), 32'h0);
    check("rst_addr", bus_if.bus_addr, 32'h0);
    check("rst_wdata", bus_if.bus_wdata, 32'h0);
    check("rst_wstrb", 32'(bus_if.bus_wstrb), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    auto_en = 1'b1;

    force_wait = 0; force_lat = 1;
    do_txn(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    ovr_en = 1'b1; ovr_val = 32'h80FF_0000; force_lat = 3;
    do_txn(1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0);
    if (!abort) check("byte_load_sext", read_data_o, 32'hFFFF_FF80);
    force_wait = 4;
    do_txn(1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h0000_ABCD);
    force_wait = 0; force_lat = 1;
    do_txn(1'b0, 2'b01, 1'b0, 32'h0000_0401, 32'h0);
    ovr_val = 32'h00F0_0000;
    do_txn(1'b0, 2'b00, 1'b0, 32'h0000_0402, 32'h0);
    if (!abort) check("byte_load_zext", read_data_o, 32'h0000_00F0);
    ovr_val = 32'h8765_4321;
    do_txn(1'b0, 2'b11, 1'b1, 32'h0000_0500, 32'h0);
    ovr_en = 1'b0; force_wait = -1; force_lat = -1;

    for (int i = 0; i < 200 && !abort; i++) begin
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    if (!abort) begin
      // Reset while waiting for a load response; the late response must be dropped.
      idle_cycles(3);
      auto_en = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; mem_write = 1'b0; type_control = 2'b10;
      sign_ext_flag = 1'b0; addr = 32'h0000_0010;
      exp_req.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, wstrb: 4'h0});
      @(posedge clk); #1;
      bus_if.bus_req_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.bus_req_ready = 1'b0;
      check("stall_wait_rsp", 32'(stall_o), 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 1'b0;
      bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rdata = 32'hCAFE_BABE;
      #1;
      check("rst_mid_stall", 32'(stall_o), 32'h0);
      check("rst_mid_req_valid", 32'(bus_if.bus_req_valid), 32'h0);
      check("rst_mid_done", 32'(done_o), 32'h0);
      @(posedge clk); #1;
      bus_if.bus_rsp_valid = 1'b0;
      check("late_rsp_done", 32'(done_o), 32'h0);
      check("late_rsp_read_data", read_data_o, 32'h0);
      @(posedge clk); #2;
      check("late_rsp_done2", 32'(done_o), 32'h0);
      last_rd = 32'h0;
      exp_req.delete();
      auto_en = 1'b1;
      do_txn(1'b1, 2'b00, 1'b0, 32'h0000_0601, 32'h0000_0055);
      do_txn(1'b0, 2'b01, 1'b1, 32'h0000_0702, 32'h0);
      idle_cycles(4);
      check("exp_req_drained", 32'(exp_req.size()), 32'h0);
      check("exp_done_drained", 32'(exp_done.size()), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
